// File: rtl/bram_port_arbiter.sv
// Purpose: two-client valid/ready front end for a true dual-port block RAM.
// Latency: read accepted at edge E0 returns rsp_valid for the cycle after E2; writes give no response.
// Backpressure: both clients ready unless same-address with a write; then round-robin grants one.
//
// Ports:
//   clk, rst               single clock, synchronous active-high reset
//   a_req_* / b_req_*      client request channels (valid/ready, we, addr, wdata)
//   a_rsp_* / b_rsp_*      read response (one-cycle valid pulse, rdata held)
//   wr_en*/rd_en*/addr*/din*  registered RAM port controls; client A -> port A, B -> port B
//   douta, doutb           RAM read data, valid one cycle after the read edge
//   conflict_cnt           saturating count of conflict cycles
module bram_port_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  a_req_valid,
  output logic                  a_req_ready,
  input  logic                  a_req_we,
  input  logic [ADDR_WIDTH-1:0] a_req_addr,
  input  logic [DATA_WIDTH-1:0] a_req_wdata,
  output logic                  a_rsp_valid,
  output logic [DATA_WIDTH-1:0] a_rsp_rdata,

  input  logic                  b_req_valid,
  output logic                  b_req_ready,
  input  logic                  b_req_we,
  input  logic [ADDR_WIDTH-1:0] b_req_addr,
  input  logic [DATA_WIDTH-1:0] b_req_wdata,
  output logic                  b_rsp_valid,
  output logic [DATA_WIDTH-1:0] b_rsp_rdata,

  output logic                  wr_ena,
  output logic                  rd_ena,
  output logic                  wr_enb,
  output logic                  rd_enb,
  output logic [ADDR_WIDTH-1:0] addra,
  output logic [ADDR_WIDTH-1:0] addrb,
  output logic [DATA_WIDTH-1:0] dina,
  output logic [DATA_WIDTH-1:0] dinb,
  input  logic [DATA_WIDTH-1:0] douta,
  input  logic [DATA_WIDTH-1:0] doutb,

  output logic [CNT_WIDTH-1:0]  conflict_cnt
);

  logic conflict;
  logic prio;       // 0: A wins the next conflict, 1: B wins
  logic a_acc;
  logic b_acc;
  logic a_rd_s2;    // read issued to RAM port A last cycle; douta valid now
  logic b_rd_s2;

  // A read/read pair on the same address is harmless for the RAM, so only
  // pairs involving a write are serialised.
  assign conflict = a_req_valid & b_req_valid &
                    (a_req_addr == b_req_addr) & (a_req_we | b_req_we);

  // Ready is a pure function of the request fields and prio; it never looks
  // at ready, so there is no combinational loop through the clients.
  assign a_req_ready = ~rst & (~conflict | ~prio);
  assign b_req_ready = ~rst & (~conflict |  prio);

  assign a_acc = a_req_valid & a_req_ready;
  assign b_acc = b_req_valid & b_req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      prio         <= 1'b0;
      conflict_cnt <= '0;
      wr_ena       <= 1'b0;
      rd_ena       <= 1'b0;
      wr_enb       <= 1'b0;
      rd_enb       <= 1'b0;
      addra        <= '0;
      addrb        <= '0;
      dina         <= '0;
      dinb         <= '0;
      a_rd_s2      <= 1'b0;
      b_rd_s2      <= 1'b0;
      a_rsp_valid  <= 1'b0;
      b_rsp_valid  <= 1'b0;
      a_rsp_rdata  <= '0;
      b_rsp_rdata  <= '0;
    end else begin
      // Toggle after each conflict so the loser wins the retry.
      if (conflict) begin
        prio <= ~prio;
        if (conflict_cnt != {CNT_WIDTH{1'b1}})
          conflict_cnt <= conflict_cnt + CNT_WIDTH'(1);
      end

      // Issue stage.
      wr_ena <= a_acc &  a_req_we;
      rd_ena <= a_acc & ~a_req_we;
      wr_enb <= b_acc &  b_req_we;
      rd_enb <= b_acc & ~b_req_we;
      // Address/data only move on accept; when idle they are don't-care and
      // holding them avoids needless toggling on the RAM pins.
      if (a_acc) begin
        addra <= a_req_addr;
        dina  <= a_req_wdata;
      end
      if (b_acc) begin
        addrb <= b_req_addr;
        dinb  <= b_req_wdata;
      end

      // RAM output is registered, so the data for a read issued at E1
      // appears after E1 and is captured one edge later.
      a_rd_s2 <= rd_ena;
      b_rd_s2 <= rd_enb;

      a_rsp_valid <= a_rd_s2;
      b_rsp_valid <= b_rd_s2;
      if (a_rd_s2) a_rsp_rdata <= douta;
      if (b_rd_s2) b_rsp_rdata <= doutb;
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Purpose: randomized and directed scoreboard bench for bram_port_arbiter.
// Latency: expected read data queued at accept, compared when rsp_valid pulses.
// Backpressure: stimulus holds a request until the reference grant accepts it.
module tb_bram_port_arbiter;

  logic        clk;
  logic        rst;
  logic        a_req_valid, a_req_ready, a_req_we;
  logic [9:0]  a_req_addr;
  logic [15:0] a_req_wdata;
  logic        a_rsp_valid;
  logic [15:0] a_rsp_rdata;
  logic        b_req_valid, b_req_ready, b_req_we;
  logic [9:0]  b_req_addr;
  logic [15:0] b_req_wdata;
  logic        b_rsp_valid;
  logic [15:0] b_rsp_rdata;
  logic        wr_ena, rd_ena, wr_enb, rd_enb;
  logic [9:0]  addra, addrb;
  logic [15:0] dina, dinb;
  logic [15:0] ram_douta, ram_doutb;
  logic [15:0] conflict_cnt;

  // Second instance with a narrow counter, driven by the same requests.
  logic        a2_ready, b2_ready, a2_rsp_valid, b2_rsp_valid;
  logic [15:0] a2_rsp_rdata, b2_rsp_rdata, dina2, dinb2;
  logic        wr_ena2, rd_ena2, wr_enb2, rd_enb2;
  logic [9:0]  addra2, addrb2;
  logic [3:0]  cnt2;

  bram_port_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
    .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
    .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
    .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
    .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata),
    .wr_ena(wr_ena), .rd_ena(rd_ena), .wr_enb(wr_enb), .rd_enb(rd_enb),
    .addra(addra), .addrb(addrb), .dina(dina), .dinb(dinb),
    .douta(ram_douta), .doutb(ram_doutb), .conflict_cnt(conflict_cnt)
  );

  bram_port_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .CNT_WIDTH(4)) dut_w4 (
    .clk(clk), .rst(rst),
    .a_req_valid(a_req_valid), .a_req_ready(a2_ready), .a_req_we(a_req_we),
    .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
    .a_rsp_valid(a2_rsp_valid), .a_rsp_rdata(a2_rsp_rdata),
    .b_req_valid(b_req_valid), .b_req_ready(b2_ready), .b_req_we(b_req_we),
    .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
    .b_rsp_valid(b2_rsp_valid), .b_rsp_rdata(b2_rsp_rdata),
    .wr_ena(wr_ena2), .rd_ena(rd_ena2), .wr_enb(wr_enb2), .rd_enb(rd_enb2),
    .addra(addra2), .addrb(addrb2), .dina(dina2), .dinb(dinb2),
    .douta(16'h0000), .doutb(16'h0000), .conflict_cnt(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // True dual-port RAM with registered outputs.
  logic [15:0] ram [1024];
  logic        ram_clr;
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 16'h0000;
    end else begin
      if (wr_ena) ram[addra] <= dina;
      if (wr_enb) ram[addrb] <= dinb;
    end
    if (rd_ena) ram_douta <= ram[addra];
    if (rd_enb) ram_doutb <= ram[addrb];
  end

  // Reference state.
  typedef struct {
    logic [15:0] d;
    int          c;
  } exp_t;
  exp_t        qa[$];
  exp_t        qb[$];
  exp_t        ea, eb;
  logic [15:0] golden [1024];
  logic        prio_m;
  int          cnt_m, cnt4_m;
  int          cyc;
  logic [15:0] last_a, last_b;
  logic        mon_en;
  int          n_chk, n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // One clock cycle of stimulus; called just after a rising edge.
  task automatic step(input logic r,
                      input logic av, input logic awe, input logic [9:0] aad, input logic [15:0] awd,
                      input logic bv, input logic bwe, input logic [9:0] bad, input logic [15:0] bwd,
                      output logic aacc, output logic bacc);
    logic conf, era, erb;
    rst = r;
    a_req_valid = av; a_req_we = awe; a_req_addr = aad; a_req_wdata = awd;
    b_req_valid = bv; b_req_we = bwe; b_req_addr = bad; b_req_wdata = bwd;
    #2;
    conf = av && bv && (aad == bad) && (awe || bwe);
    era  = !r && (!conf || !prio_m);
    erb  = !r && (!conf ||  prio_m);
    chk("a_req_ready", a_req_ready, era);
    chk("b_req_ready", b_req_ready, erb);
    chk("conflict_cnt", conflict_cnt, cnt_m);
    chk("conflict_cnt_w4", cnt2, cnt4_m);
    aacc = av && era;
    bacc = bv && erb;
    @(posedge clk);
    if (r) begin
      prio_m = 1'b0; cnt_m = 0; cnt4_m = 0;
      last_a = 16'h0; last_b = 16'h0;
      // Anything not yet delivered by this edge is lost.
      while (qa.size() > 0 && qa[$].c > cyc) void'(qa.pop_back());
      while (qb.size() > 0 && qb[$].c > cyc) void'(qb.pop_back());
    end else begin
      if (conf) begin
        prio_m = !prio_m;
        if (cnt_m < 65535) cnt_m++;
        if (cnt4_m < 15) cnt4_m++;
      end
      if (aacc && !awe) qa.push_back('{golden[aad], cyc + 3});
      if (bacc && !bwe) qb.push_back('{golden[bad], cyc + 3});
      if (aacc && awe) golden[aad] = awd;
      if (bacc && bwe) golden[bad] = bwd;
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    logic x, y;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 10'd0, 16'h0, 1'b0, 1'b0, 10'd0, 16'h0, x, y);
  endtask

  task automatic do_reset();
    logic x, y;
    step(1'b1, 1'b0, 1'b0, 10'd0, 16'h0, 1'b0, 1'b0, 10'd0, 16'h0, x, y);
  endtask

  task automatic check_zero();
    chk("rst_a_ready", a_req_ready, 0);
    chk("rst_b_ready", b_req_ready, 0);
    chk("rst_enables", {wr_ena, rd_ena, wr_enb, rd_enb}, 0);
    chk("rst_addra", addra, 0);
    chk("rst_addrb", addrb, 0);
    chk("rst_dina", dina, 0);
    chk("rst_dinb", dinb, 0);
    chk("rst_rsp_valid", {a_rsp_valid, b_rsp_valid}, 0);
    chk("rst_a_rdata", a_rsp_rdata, 0);
    chk("rst_b_rdata", b_rsp_rdata, 0);
    chk("rst_conflict_cnt", conflict_cnt, 0);
  endtask

  // Response monitor: pops the scoreboard whenever a response appears.
  always @(negedge clk) begin
    if (mon_en) begin
      if (a_rsp_valid) begin
        if (qa.size() == 0) fail("a_rsp_unexpected", a_rsp_rdata, 0);
        else begin
          ea = qa.pop_front();
          chk("a_rsp_rdata", a_rsp_rdata, ea.d);
          chk("a_rsp_cycle", cyc, ea.c);
          last_a = ea.d;
        end
      end else begin
        chk("a_rdata_hold", a_rsp_rdata, last_a);
        if (qa.size() > 0 && qa[0].c <= cyc) begin
          fail("a_rsp_missing", cyc, qa[0].c);
          void'(qa.pop_front());
        end
      end
      if (b_rsp_valid) begin
        if (qb.size() == 0) fail("b_rsp_unexpected", b_rsp_rdata, 0);
        else begin
          eb = qb.pop_front();
          chk("b_rsp_rdata", b_rsp_rdata, eb.d);
          chk("b_rsp_cycle", cyc, eb.c);
          last_b = eb.d;
        end
      end else begin
        chk("b_rdata_hold", b_rsp_rdata, last_b);
        if (qb.size() > 0 && qb[0].c <= cyc) begin
          fail("b_rsp_missing", cyc, qb[0].c);
          void'(qb.pop_front());
        end
      end
    end
  end

  initial begin
    logic        aa, ba;
    logic        pav, pawe, pbv, pbwe;
    logic [9:0]  paa, pba;
    logic [15:0] pad, pbd;
    n_chk = 0; n_fail = 0; cyc = 0; mon_en = 1'b0;
    prio_m = 1'b0; cnt_m = 0; cnt4_m = 0; last_a = 16'h0; last_b = 16'h0;
    for (int i = 0; i < 1024; i++) golden[i] = 16'h0;
    ram_clr = 1'b1;
    do_reset();
    ram_clr = 1'b0;
    check_zero();
    mon_en = 1'b1;

    // Parallel writes, then crossed reads.
    step(1'b0, 1'b1, 1'b1, 10'd5, 16'h1234, 1'b1, 1'b1, 10'd9, 16'hBEEF, aa, ba);
    step(1'b0, 1'b1, 1'b0, 10'd9, 16'h0,    1'b1, 1'b0, 10'd5, 16'h0,    aa, ba);
    idle(4);

    // Write/write conflict on address 7: A then B, then read back.
    step(1'b0, 1'b1, 1'b1, 10'd7, 16'h00AA, 1'b1, 1'b1, 10'd7, 16'h00BB, aa, ba);
    step(1'b0, 1'b0, 1'b0, 10'd0, 16'h0,    1'b1, 1'b1, 10'd7, 16'h00BB, aa, ba);
    chk("cnt_after_ww", conflict_cnt, 1);
    step(1'b0, 1'b1, 1'b0, 10'd7, 16'h0,    1'b0, 1'b0, 10'd0, 16'h0,    aa, ba);
    idle(4);

    // Back-to-back A-write / B-read conflicts on address 3.
    do_reset();
    step(1'b0, 1'b1, 1'b1, 10'd3, 16'h1111, 1'b1, 1'b0, 10'd3, 16'h0, aa, ba);
    step(1'b0, 1'b1, 1'b1, 10'd3, 16'h2222, 1'b1, 1'b0, 10'd3, 16'h0, aa, ba);
    step(1'b0, 1'b1, 1'b1, 10'd3, 16'h2222, 1'b1, 1'b0, 10'd3, 16'h0, aa, ba);
    chk("cnt_after_3", conflict_cnt, 3);
    step(1'b0, 1'b0, 1'b0, 10'd0, 16'h0,    1'b1, 1'b0, 10'd3, 16'h0, aa, ba);
    idle(4);

    // Read/read on the same address is not a conflict.
    step(1'b0, 1'b1, 1'b1, 10'd12, 16'h5555, 1'b0, 1'b0, 10'd0, 16'h0, aa, ba);
    step(1'b0, 1'b1, 1'b0, 10'd12, 16'h0,    1'b1, 1'b0, 10'd12, 16'h0, aa, ba);
    chk("cnt_rr_unchanged", conflict_cnt, 3);
    idle(4);

    // Reset one cycle after reads are accepted: reads vanish, prio back to A.
    step(1'b0, 1'b1, 1'b0, 10'd1, 16'h0, 1'b1, 1'b0, 10'd2, 16'h0, aa, ba);
    do_reset();
    check_zero();
    idle(5);
    check_zero_after: begin
      chk("post_rst_enables", {wr_ena, rd_ena, wr_enb, rd_enb}, 0);
      chk("post_rst_rsp_valid", {a_rsp_valid, b_rsp_valid}, 0);
    end
    step(1'b0, 1'b1, 1'b1, 10'd4, 16'h4444, 1'b1, 1'b1, 10'd4, 16'h5454, aa, ba);
    step(1'b0, 1'b0, 1'b0, 10'd0, 16'h0,    1'b1, 1'b1, 10'd4, 16'h5454, aa, ba);
    idle(2);

    // Randomized traffic over a small address window to provoke conflicts.
    pav = 1'b0; pbv = 1'b0;
    pawe = 1'b0; pbwe = 1'b0; paa = 10'd0; pba = 10'd0; pad = 16'h0; pbd = 16'h0;
    for (int n = 0; n < 400; n++) begin
      if (!pav && $urandom_range(0, 9) < 7) begin
        pav = 1'b1; pawe = 1'($urandom_range(0, 1));
        paa = 10'($urandom_range(0, 7)); pad = 16'($urandom);
      end
      if (!pbv && $urandom_range(0, 9) < 7) begin
        pbv = 1'b1; pbwe = 1'($urandom_range(0, 1));
        pba = 10'($urandom_range(0, 7)); pbd = 16'($urandom);
      end
      step(1'b0, pav, pawe, paa, pad, pbv, pbwe, pba, pbd, aa, ba);
      if (aa) pav = 1'b0;
      if (ba) pbv = 1'b0;
    end
    idle(5);

    // Continuous conflict for 20 cycles: narrow counter saturates at 0xF.
    do_reset();
    for (int i = 0; i < 20; i++)
      step(1'b0, 1'b1, 1'b1, 10'd3, 16'(i), 1'b1, 1'b1, 10'd3, 16'(i + 100), aa, ba);
    chk("cnt_w4_saturated", cnt2, 32'hF);
    chk("cnt_w16_20", conflict_cnt, 20);
    idle(5);

    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
